// File: rtl/drum_compositor.sv
// Sprite compositor for the drum pads: picks the highest-priority lit sprite,
// dims idle pads, flashes hit pads for a number of frames, and realigns video syncs.
module drum_compositor #(
  parameter int NUM_PADS     = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int PIPE_DELAY   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic                    blank,
  input  logic [24*NUM_PADS-1:0]  pad_pixels,
  input  logic [NUM_PADS-1:0]     hit,
  output logic                    phsync,
  output logic                    pvsync,
  output logic                    pblank,
  output logic [23:0]             pixel_out,
  output logic [NUM_PADS-1:0]     flash_active
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Each stage carries {hsync, vsync, blank}
  logic [PIPE_DELAY-1:0][2:0] sync_pipe_q, sync_pipe_d;
  logic [2:0]                 sync_out_q, sync_out_d;
  logic                       vsync_q, vsync_d;
  logic                       tick;
  logic [NUM_PADS-1:0]        pending_q, pending_d;
  logic [NUM_PADS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_PADS-1:0]        flash_q, flash_d;
  logic [23:0]                pixel_q, pixel_d;
  logic [23:0]                win_pix;
  logic                       win_flash;
  logic                       win_found;
  logic                       blank_dly;

  // vsync_q resets high so a low vsync at reset release is not mistaken for an edge
  assign tick      = vsync_q & ~vsync;
  assign blank_dly = sync_pipe_q[PIPE_DELAY-1][0];

  always_comb begin
    sync_pipe_d    = sync_pipe_q;
    sync_pipe_d[0] = {hsync, vsync, blank};
    for (int k = 1; k < PIPE_DELAY; k++) begin
      sync_pipe_d[k] = sync_pipe_q[k-1];
    end
    sync_out_d = sync_pipe_q[PIPE_DELAY-1];
    vsync_d    = vsync;
  end

  always_comb begin
    pending_d = tick ? '0 : (pending_q | hit);
    cnt_d     = cnt_q;
    flash_d   = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      // A hit landing in the tick cycle itself still loads at that tick
      if (tick) begin
        if (pending_q[i] | hit[i]) begin
          cnt_d[i] = LOAD_VAL;
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - ONE;
        end
      end
      flash_d[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    win_pix   = '0;
    win_flash = 1'b0;
    win_found = 1'b0;
    // Scan high to low so the lowest nonzero pad overwrites the rest
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (pad_pixels[24*i +: 24] != 24'd0) begin
        win_pix   = pad_pixels[24*i +: 24];
        win_flash = flash_q[i];
        win_found = 1'b1;
      end
    end
    pixel_d = '0;
    if (!blank_dly && win_found) begin
      if (win_flash) begin
        pixel_d = win_pix;
      end else begin
        pixel_d = {2'b00, win_pix[23:18], 2'b00, win_pix[15:10], 2'b00, win_pix[7:2]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pipe_q <= '1;
      sync_out_q  <= '1;
      vsync_q     <= 1'b1;
      pending_q   <= '0;
      cnt_q       <= '0;
      flash_q     <= '0;
      pixel_q     <= '0;
    end else begin
      sync_pipe_q <= sync_pipe_d;
      sync_out_q  <= sync_out_d;
      vsync_q     <= vsync_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      flash_q     <= flash_d;
      pixel_q     <= pixel_d;
    end
  end

  assign phsync       = sync_out_q[2];
  assign pvsync       = sync_out_q[1];
  assign pblank       = sync_out_q[0];
  assign pixel_out    = pixel_q;
  assign flash_active = flash_q;

endmodule

// File: tb/tb_drum_compositor.sv
// Directed bench for drum_compositor: pixel selection table plus hand-written
// sequences for sync latency, blanking, flash timing, retrigger and reset.
module tb_drum_compositor;

  localparam int NP = 4;
  localparam int FF = 8;
  localparam int PD = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             hsync = 1'b1;
  logic             vsync = 1'b1;
  logic             blank = 1'b0;
  logic [24*NP-1:0] pad_pixels = '0;
  logic [NP-1:0]    hit = '0;
  logic             phsync, pvsync, pblank;
  logic [23:0]      pixel_out;
  logic [NP-1:0]    flash_active;

  int checks_total  = 0;
  int checks_passed = 0;

  drum_compositor #(.NUM_PADS(NP), .FLASH_FRAMES(FF), .PIPE_DELAY(PD)) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pad_pixels(pad_pixels), .hit(hit), .phsync(phsync), .pvsync(pvsync),
    .pblank(pblank), .pixel_out(pixel_out), .flash_active(flash_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] p0, p1, p2, p3;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_pads(input logic [23:0] p0, p1, p2, p3);
    pad_pixels = {p3, p2, p1, p0};
  endtask

  // Falling vsync for one edge (the tick edge), then back high for one edge
  task automatic frame_tick(input logic [NP-1:0] hmask);
    vsync = 1'b0;
    hit   = hmask;
    step();
    vsync = 1'b1;
    hit   = '0;
    step();
  endtask

  task automatic pulse_hit(input logic [NP-1:0] hmask);
    hit = hmask;
    step();
    hit = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"idle_dim_pad0",    24'hFF8040, 24'h0,      24'h0,      24'h0,      24'h3F2010};
    vecs[1] = '{"prio_pad0_pad2",   24'h0000FF, 24'h0,      24'hFF0000, 24'h0,      24'h00003F};
    vecs[2] = '{"all_zero",         24'h0,      24'h0,      24'h0,      24'h0,      24'h000000};
    vecs[3] = '{"pad3_only",        24'h0,      24'h0,      24'h0,      24'h123456, 24'h040D15};
    vecs[4] = '{"pad1_dims_to_0",   24'h0,      24'h030303, 24'h0,      24'hFFFFFF, 24'h000000};
    vecs[5] = '{"pad2_over_pad3",   24'h0,      24'h0,      24'h000400, 24'hFFFFFF, 24'h000100};
    vecs[6] = '{"full_white_dim",   24'hFFFFFF, 24'h0,      24'h0,      24'h0,      24'h3F3F3F};

    // Reset state, with busy inputs to show outputs are held
    set_pads(24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0);
    blank = 1'b0;
    hsync = 1'b0;
    repeat (3) step();
    check("rst_pixel", pixel_out, 24'h0);
    check("rst_pblank", {23'b0, pblank}, 24'h1);
    check("rst_phsync", {23'b0, phsync}, 24'h1);
    check("rst_pvsync", {23'b0, pvsync}, 24'h1);
    check("rst_flash", {20'b0, flash_active}, 24'h0);

    hsync = 1'b1;
    set_pads(24'h0, 24'h0, 24'h0, 24'h0);
    reset_n = 1'b1;
    repeat (PD + 3) step();

    // Sync latency: input changed after edge E0 shows after edge E0+PD+1
    hsync = 1'b0;
    for (int i = 1; i <= PD + 1; i++) begin
      step();
      check($sformatf("phsync_lat_e%0d", i), {23'b0, phsync}, (i <= PD) ? 24'h1 : 24'h0);
    end
    hsync = 1'b1;
    repeat (PD + 2) step();
    check("phsync_back", {23'b0, phsync}, 24'h1);

    // Pixel selection table, no pad flashing
    for (int v = 0; v < 7; v++) begin
      set_pads(vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3);
      step();
      check(vecs[v].name, pixel_out, vecs[v].exp);
    end

    // Blank applied at the input lines up with pblank
    set_pads(24'h0000FF, 24'h0, 24'hFF0000, 24'h0);
    blank = 1'b1;
    repeat (PD) step();
    check("blank_pre_pixel", pixel_out, 24'h00003F);
    check("blank_pre_pblank", {23'b0, pblank}, 24'h0);
    step();
    check("blank_pixel", pixel_out, 24'h0);
    check("blank_pblank", {23'b0, pblank}, 24'h1);
    blank = 1'b0;
    repeat (PD + 2) step();
    check("unblank_pixel", pixel_out, 24'h00003F);

    // Flash of pad1 after a mid-frame hit
    set_pads(24'h0, 24'hFFFFFF, 24'h0, 24'h0);
    pulse_hit(4'b0010);
    repeat (3) step();
    check("hit_no_flash_yet", {20'b0, flash_active}, 24'h0);
    vsync = 1'b0;
    step();
    check("tick_edge_flash_old", {20'b0, flash_active}, 24'h0);
    vsync = 1'b1;
    step();
    check("flash1_on", {20'b0, flash_active}, 24'h2);
    step();
    check("flash1_pixel", pixel_out, 24'hFFFFFF);
    set_pads(24'h808080, 24'hFFFFFF, 24'h0, 24'h0);
    step();
    check("dim_pad0_over_flash1", pixel_out, 24'h202020);
    set_pads(24'h0, 24'hFFFFFF, 24'h0, 24'h0);
    for (int t = 1; t <= FF; t++) begin
      frame_tick('0);
      check($sformatf("flash1_tick%0d", t), {20'b0, flash_active}, (t < FF) ? 24'h2 : 24'h0);
    end
    step();
    check("flash1_off_pixel", pixel_out, 24'h3F3F3F);

    // Hit on the tick cycle, then retrigger after 5 ticks
    set_pads(24'h0, 24'h0, 24'h0, 24'h0);
    frame_tick(4'b0001);
    check("tickhit_load", {20'b0, flash_active}, 24'h1);
    for (int t = 1; t <= 5; t++) frame_tick('0);
    check("retrig_before", {20'b0, flash_active}, 24'h1);
    pulse_hit(4'b0001);
    pulse_hit(4'b0001);
    for (int t = 6; t <= 14; t++) begin
      frame_tick('0);
      check($sformatf("retrig_tick%0d", t), {20'b0, flash_active}, (t < 14) ? 24'h1 : 24'h0);
    end

    // Reset in the middle of a pad2 flash (counter at 5)
    frame_tick(4'b0100);
    for (int t = 1; t <= 3; t++) frame_tick('0);
    check("pre_reset_flash2", {20'b0, flash_active}, 24'h4);
    set_pads(24'h0, 24'h0, 24'h123456, 24'h0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_flash", {20'b0, flash_active}, 24'h0);
    check("async_rst_pixel", pixel_out, 24'h0);
    check("async_rst_pblank", {23'b0, pblank}, 24'h1);
    step();
    step();
    reset_n = 1'b1;
    repeat (PD + 2) step();
    check("post_rst_flash", {20'b0, flash_active}, 24'h0);
    frame_tick('0);
    check("post_rst_tick_flash", {20'b0, flash_active}, 24'h0);
    step();
    check("post_rst_pixel_dim", pixel_out, 24'h040D15);
    frame_tick(4'b0100);
    check("post_rst_rehit", {20'b0, flash_active}, 24'h4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/drum_compositor.md
# drum_compositor

Pixel-stage compositor directly downstream of the per-pad `circle` sprite generators. It merges NUM_PADS sprite pixel streams into one RGB pixel and applies frame-synchronous hit flashing. Each pad is drawn dim when idle and at full brightness for FLASH_FRAMES frames after a hit. It also delays hsync/vsync/blank so they stay aligned with the sprite pipeline latency before driving the video output.

## Interface
Parameters:
- NUM_PADS, 4, number of sprite inputs; range 1..8.
- FLASH_FRAMES, 8, frames a pad stays bright after a hit; range 1..255.
- PIPE_DELAY, 3, cycles from hcount/vcount to a valid sprite pixel (matches `circle`).

Ports:
- clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hsync  in  1  raw horizontal sync from the timing generator, active-low.
- vsync  in  1  raw vertical sync, active-low.
- blank  in  1  raw blanking, active-high.
- pad_pixels  in  24*NUM_PADS  sprite pixels; pad i occupies [24*i+23:24*i], RGB 8:8:8.
- hit  in  NUM_PADS  one-cycle hit pulses from the drum detector, any alignment to video.
- phsync  out  1  hsync delayed PIPE_DELAY+1 cycles.
- pvsync  out  1  vsync delayed PIPE_DELAY+1 cycles.
- pblank  out  1  blank delayed PIPE_DELAY+1 cycles.
- pixel_out  out  24  composited pixel, aligned with phsync/pvsync/pblank.
- flash_active  out  NUM_PADS  bit i is 1 while pad i's flash counter is nonzero.

## Operation
- Reset: counters, pending bits, pixel_out and flash_active are 0. phsync, pvsync and pblank are 1, as are all sync delay stages.
- Sync delay: hsync, vsync and blank pass through a PIPE_DELAY-stage shift register plus the output register. Total latency is PIPE_DELAY+1, with no combinational path from input to output.
- Frame tick:
  - Asserted for one cycle when raw vsync is seen falling (1→0) against a registered copy of vsync.
  - The first frame after reset produces no tick until a real falling edge occurs.
- Per-pad hit capture:
  - A hit[i] pulse sets pending[i].
  - Extra hits before the next tick are absorbed into the same pending bit.
- Per-pad flash counter, width ceil(log2(FLASH_FRAMES+1)), updated only on a tick:
  - If pending[i] is set (including a hit arriving in the tick cycle itself), load FLASH_FRAMES and clear pending[i].
  - Otherwise, if the counter is nonzero, decrement it.
  - The counter saturates at 0.
  - A retrigger while active reloads FLASH_FRAMES; it never adds.
- flash_active[i] = (counter[i] != 0), registered. It changes only in the cycle after a tick, so brightness never changes mid-frame.
- Pixel selection (combinational on the current pad_pixels, then registered into pixel_out):
  - The winner is the lowest index i whose 24-bit pixel is nonzero.
  - If flash_active[i] = 1: output the pad pixel unchanged.
  - If flash_active[i] = 0: shift each 8-bit channel right by 2 (quarter brightness, truncating).
  - If no pad pixel is nonzero: output 0.
  - If the delayed blank (the stage feeding pblank) is 1: output 0, regardless of the pads.

## Timing
- pad_pixels sampled at edge n appears on pixel_out after edge n+1, which is the same cycle raw sync sampled at edge n−PIPE_DELAY appears on phsync/pvsync/pblank.
- hit to flash_active: takes effect one cycle after the next frame tick, i.e. at most one frame plus 2 cycles.
- Flash duration: exactly FLASH_FRAMES ticks. flash_active falls one cycle after the FLASH_FRAMES-th tick following the load.
- Reset asserted mid-frame: all state clears immediately (asynchronous). Outputs hold their reset values until reset_n deasserts, and the sync delay refills over PIPE_DELAY+1 cycles.

## Test plan
- Reset and latency: drive hsync 1→0 at cycle 10 with PIPE_DELAY=3 → phsync falls after edge 14. While reset_n=0: pixel_out=0, pblank=1.
- Idle dim: pad0 pixel 24'hFF_80_40, no hits → pixel_out = 24'h3F_20_10 four cycles later.
- Flash: hit[1] mid-frame with pad1 pixel 24'hFF_FF_FF and FLASH_FRAMES=8 →
  - after the next vsync falling edge, pixel_out = 24'hFF_FF_FF and flash_active[1]=1;
  - after the 8th tick, output returns to 24'h3F_3F_3F.
- Priority and blank:
  - pad0=24'h00_00_FF and pad2=24'hFF_00_00 together → output 24'h00_00_3F.
  - same pads with blank=1 at the input → pixel_out=0 at the matching delayed cycle.
- Hit on the tick cycle and retrigger:
  - hit[0] in the same cycle as the vsync falling edge → counter loads 8 at that tick.
  - hit[0] again after 5 ticks → counter reloads 8 at the next tick; flash lasts 14 ticks in total.
- Reset mid-flash: reset_n low for 2 cycles while counter[2]=5 → flash_active[2]=0 immediately and stays 0 after release until a new hit plus tick.
